// File: rtl/sram_bank_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank_loader_if
//  Description : Bus bundle for the SRAM bank preload engine. It carries the
//                load-command handshake, the valid/ready word stream, the
//                registered SRAM write port and the status outputs.
//                master : host/scan loader side (issues commands, streams
//                         words, observes status and the write port)
//                slave  : sram_bank_loader side
//  Ports       : cfg_valid/cfg_ready/cfg_bank/cfg_base/cfg_len/cfg_mode,
//                in_valid/in_ready/in_data,
//                sram_wen/sram_addr/sram_wdata,
//                busy/load_done/err_overflow/words_loaded
//  Revision    : 1.0  initial release
// ============================================================================
interface sram_bank_loader_if #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BSEL_W    = $clog2(NUM_BANKS),
    parameter int LEN_W     = ADDR_W + BSEL_W + 1
);
    // Command channel
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [BSEL_W-1:0]    cfg_bank;
    logic [ADDR_W-1:0]    cfg_base;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_mode;
    // Word stream
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_data;
    // SRAM write port
    logic [NUM_BANKS-1:0] sram_wen;
    logic [ADDR_W-1:0]    sram_addr;
    logic [DATA_W-1:0]    sram_wdata;
    // Status
    logic                 busy;
    logic                 load_done;
    logic                 err_overflow;
    logic [LEN_W-1:0]     words_loaded;

    modport master (
        output cfg_valid, cfg_bank, cfg_base, cfg_len, cfg_mode,
        output in_valid, in_data,
        input  cfg_ready, in_ready,
        input  sram_wen, sram_addr, sram_wdata,
        input  busy, load_done, err_overflow, words_loaded
    );

    modport slave (
        input  cfg_valid, cfg_bank, cfg_base, cfg_len, cfg_mode,
        input  in_valid, in_data,
        output cfg_ready, in_ready,
        output sram_wen, sram_addr, sram_wdata,
        output busy, load_done, err_overflow, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/sram_bank_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bank_loader
//  Description : Preload engine for the banked on-chip SRAMs. Accepts a load
//                command, then writes each streamed word into a bank, either
//                sequentially within one bank or round-robin across banks.
//                Each accepted word appears on the registered write port one
//                cycle after its handshake. Words that would land beyond the
//                last bank address are still accepted (so the stream drains)
//                but are dropped and flagged in a sticky overflow bit.
//  Ports       : clk    - clock
//                reset  - asynchronous, active-high reset
//                bus    - sram_bank_loader_if.slave (command, stream, SRAM
//                         write port, status)
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bank_loader #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int BSEL_W    = $clog2(NUM_BANKS),
    parameter int LEN_W     = ADDR_W + BSEL_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_bank_loader_if.slave     bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Address arithmetic is carried one bit wider than the length so that
    // base + offset can never wrap back into the legal range.
    localparam logic [LEN_W:0] c_ADDR_MAX = (LEN_W + 1)'(DEPTH - 1);

    logic [1:0]           r_state;
    logic [BSEL_W-1:0]    r_bank;
    logic [ADDR_W-1:0]    r_base;
    logic [LEN_W-1:0]     r_len;
    logic                 r_mode;
    logic [LEN_W-1:0]     r_cnt;     // handshakes taken so far (k)
    logic [NUM_BANKS-1:0] r_wen;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_ovf;
    logic [LEN_W-1:0]     r_words;

    logic                 w_cfg_fire;
    logic                 w_in_fire;
    logic                 w_last;
    logic [LEN_W-1:0]     w_off;
    logic [LEN_W:0]       w_addr_full;
    logic                 w_ovf;
    logic [BSEL_W-1:0]    w_bank;

    assign w_cfg_fire = bus.cfg_valid && (r_state == c_IDLE);
    assign w_in_fire  = bus.in_valid  && (r_state == c_LOAD);
    assign w_last     = (r_cnt == (r_len - LEN_W'(1)));

    // Interleaved mode advances the address once per full sweep of banks.
    assign w_off       = r_mode ? (r_cnt >> BSEL_W) : r_cnt;
    assign w_addr_full = {1'b0, w_off} + (LEN_W + 1)'(r_base);
    assign w_ovf       = (w_addr_full > c_ADDR_MAX);
    // Bank index wraps naturally by truncation to BSEL_W bits.
    assign w_bank      = r_mode ? (r_bank + r_cnt[BSEL_W-1:0]) : r_bank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_bank  <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_wen   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ovf   <= 1'b0;
            r_words <= '0;
        end else begin
            // Write enable is a single-cycle strobe per accepted word.
            r_wen <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_cfg_fire) begin
                        r_bank  <= bus.cfg_bank;
                        r_base  <= bus.cfg_base;
                        r_len   <= bus.cfg_len;
                        r_mode  <= bus.cfg_mode;
                        r_cnt   <= '0;
                        r_words <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (bus.cfg_len == '0) ? c_DONE : c_LOAD;
                    end
                end
                c_LOAD: begin
                    if (w_in_fire) begin
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_ovf) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_wen   <= NUM_BANKS'(1) << w_bank;
                            r_addr  <= w_addr_full[ADDR_W-1:0];
                            r_wdata <= bus.in_data;
                            r_words <= r_words + LEN_W'(1);
                        end
                        if (w_last) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.cfg_ready    = (r_state == c_IDLE);
    assign bus.in_ready     = (r_state == c_LOAD);
    assign bus.busy         = (r_state != c_IDLE);
    assign bus.load_done    = (r_state == c_DONE);
    assign bus.sram_wen     = r_wen;
    assign bus.sram_addr    = r_addr;
    assign bus.sram_wdata   = r_wdata;
    assign bus.err_overflow = r_ovf;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire
